// File: rtl/branch_unit.sv
// branch_unit: two-stage branch resolution pipeline.
//   S0 holds the accepted operands; the branch outcome is computed
//   combinationally from S0 and captured in S1, which drives out_*.
//   Optional: define BRANCH_UNIT_STATS_EN to add a saturating
//   mispredict counter on stat_mispredicts.
module branch_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_rs1,
    input  logic [31:0] in_rs2,
    input  logic [2:0]  in_params,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_offset,
    input  logic        in_pred_taken,
    input  logic [3:0]  in_tag,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_taken,
    output logic        out_mispredict,
    output logic [31:0] out_target,
`ifdef BRANCH_UNIT_STATS_EN
    output logic [3:0]  out_tag,
    output logic [31:0] stat_mispredicts
`else
    output logic [3:0]  out_tag
`endif
);

    // Occupancy encodes the S0/S1 valid bits directly: {s1, s0}.
    typedef enum logic [1:0] {
        EMPTY   = 2'b00,
        S0_ONLY = 2'b01,
        S1_ONLY = 2'b10,
        FULL    = 2'b11
    } occ_e;

    occ_e        state_q, state_d;
    logic        s0_vld, s1_vld, s1_adv, accept, s1_load;

    // S0 operand register
    logic [31:0] rs1_q, rs2_q, pc_q, off_q;
    logic [2:0]  params_q;
    logic        pred_q;
    logic [3:0]  tag_q;

    // S1 result register
    logic        taken_q, mis_q;
    logic [31:0] tgt_q;
    logic [3:0]  otag_q;

    // Outcome computed from S0
    logic        lt, taken_c;
    logic [31:0] tgt_c;

    assign s0_vld   = state_q[0];
    assign s1_vld   = state_q[1];
    assign s1_adv   = !s1_vld || out_ready;
    assign in_ready = !flush && (!s0_vld || s1_adv);
    assign accept   = in_valid && in_ready;
    assign s1_load  = s0_vld && s1_adv;

    // Occupancy register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= EMPTY;
        else        state_q <= state_d;
    end

    // Next occupancy: flush wins over everything, including a new accept
    always_comb begin
        logic s0_n, s1_n;
        state_d = state_q;
        s0_n    = accept || (s0_vld && !s1_adv);
        s1_n    = s1_load || (s1_vld && !out_ready);
        if (flush) begin
            s0_n = 1'b0;
            s1_n = 1'b0;
        end
        case ({s1_n, s0_n})
            2'b00:   state_d = EMPTY;
            2'b01:   state_d = S0_ONLY;
            2'b10:   state_d = S1_ONLY;
            default: state_d = FULL;
        endcase
    end

    // Branch condition and target from the S0 operands
    always_comb begin
        lt = params_q[2] ? (rs1_q < rs2_q) : ($signed(rs1_q) < $signed(rs2_q));
        case (params_q[1:0])
            2'b00:   taken_c = (rs1_q == rs2_q);
            2'b01:   taken_c = (rs1_q != rs2_q);
            2'b10:   taken_c = lt;
            default: taken_c = !lt;
        endcase
        tgt_c = taken_c ? (pc_q + off_q) : (pc_q + 32'd4);
    end

    // S0 capture on accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rs1_q    <= '0;
            rs2_q    <= '0;
            pc_q     <= '0;
            off_q    <= '0;
            params_q <= '0;
            pred_q   <= 1'b0;
            tag_q    <= '0;
        end else if (accept) begin
            rs1_q    <= in_rs1;
            rs2_q    <= in_rs2;
            pc_q     <= in_pc;
            off_q    <= in_offset;
            params_q <= in_params;
            pred_q   <= in_pred_taken;
            tag_q    <= in_tag;
        end
    end

    // S1 capture when S1 can advance; data only holds while stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            taken_q <= 1'b0;
            mis_q   <= 1'b0;
            tgt_q   <= '0;
            otag_q  <= '0;
        end else if (s1_load) begin
            taken_q <= taken_c;
            mis_q   <= taken_c ^ pred_q;
            tgt_q   <= tgt_c;
            otag_q  <= tag_q;
        end
    end

    assign out_valid      = s1_vld;
    assign out_taken      = taken_q;
    assign out_mispredict = mis_q;
    assign out_target     = tgt_q;
    assign out_tag        = otag_q;

`ifdef BRANCH_UNIT_STATS_EN
    logic [31:0] stat_q, stat_d;

    // Saturating count of consumed mispredicted results; flush does not touch it
    always_comb begin
        stat_d = stat_q;
        if (out_valid && out_ready && out_mispredict && stat_q != 32'hFFFF_FFFF)
            stat_d = stat_q + 32'd1;
    end

    // Counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stat_q <= '0;
        else        stat_q <= stat_d;
    end

    assign stat_mispredicts = stat_q;
`endif

endmodule

// File: tb/tb_branch_unit.sv
// Directed bench for branch_unit with a scoreboard queue of expected results.
module tb_branch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [31:0] in_rs1, in_rs2, in_pc, in_offset;
    logic [2:0]  in_params;
    logic        in_pred_taken;
    logic [3:0]  in_tag;
    logic        flush;
    logic        out_valid, out_ready, out_taken, out_mispredict;
    logic [31:0] out_target;
    logic [3:0]  out_tag;
`ifdef BRANCH_UNIT_STATS_EN
    logic [31:0] stat_mispredicts;
`endif

    int n_cmp = 0;
    int n_err = 0;

    typedef struct packed {
        logic        taken;
        logic        mis;
        logic [31:0] tgt;
        logic [3:0]  tag;
    } exp_t;

    exp_t q[$];

    branch_unit dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_params(in_params),
        .in_pc(in_pc), .in_offset(in_offset),
        .in_pred_taken(in_pred_taken), .in_tag(in_tag),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_taken(out_taken), .out_mispredict(out_mispredict),
        .out_target(out_target),
`ifdef BRANCH_UNIT_STATS_EN
        .out_tag(out_tag),
        .stat_mispredicts(stat_mispredicts)
`else
        .out_tag(out_tag)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model of one branch op
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic [2:0] p, input logic [31:0] pc,
                                   input logic [31:0] off, input logic pred,
                                   input logic [3:0] tag);
        exp_t e;
        logic lt_s, lt_u, t;
        lt_u = (a < b);
        lt_s = (a[31] != b[31]) ? a[31] : lt_u;
        case (p[1:0])
            2'b00:   t = (a == b);
            2'b01:   t = !(a == b);
            2'b10:   t = p[2] ? lt_u : lt_s;
            default: t = p[2] ? !lt_u : !lt_s;
        endcase
        e.taken = t;
        e.mis   = (t != pred);
        e.tgt   = t ? pc + off : pc + 32'd4;
        e.tag   = tag;
        return e;
    endfunction

    // Monitor: compare held output against scoreboard head, pop on handshake,
    // push expected result for every accepted op
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid) begin
                if (q.size() == 0) begin
                    chk("spurious_out_tag", 32'(out_tag), 32'hDEAD);
                end else begin
                    chk("out_taken",  32'(out_taken),      32'(q[0].taken));
                    chk("out_mispr",  32'(out_mispredict), 32'(q[0].mis));
                    chk("out_target", out_target,          q[0].tgt);
                    chk("out_tag",    32'(out_tag),        32'(q[0].tag));
                    if (out_ready) void'(q.pop_front());
                end
            end
            if (in_valid && in_ready)
                q.push_back(model(in_rs1, in_rs2, in_params, in_pc, in_offset,
                                  in_pred_taken, in_tag));
        end
    end

    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [2:0] p,
                         input logic [31:0] pc, input logic [31:0] off,
                         input logic pred, input logic [3:0] tag);
        in_valid = 1'b1; in_rs1 = a; in_rs2 = b; in_params = p;
        in_pc = pc; in_offset = off; in_pred_taken = pred; in_tag = tag;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 40 && q.size() != 0; i++) @(negedge clk);
        chk(tag, 32'(q.size()), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        in_rs1 = '0; in_rs2 = '0; in_params = '0; in_pc = '0; in_offset = '0;
        in_pred_taken = 1'b0; in_tag = '0;

        // Reset values
        #2;
        chk("rst_out_valid",  32'(out_valid), 32'd0);
        chk("rst_out_taken",  32'(out_taken), 32'd0);
        chk("rst_out_mispr",  32'(out_mispredict), 32'd0);
        chk("rst_out_target", out_target, 32'd0);
        chk("rst_out_tag",    32'(out_tag), 32'd0);
`ifdef BRANCH_UNIT_STATS_EN
        chk("rst_stat", stat_mispredicts, 32'd0);
`endif
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("in_ready_after_rst", 32'(in_ready), 32'd1);

        // LT signed: -1 < 1, predicted not-taken; latency check
        tick();
        drive(32'hFFFF_FFFF, 32'd1, 3'b010, 32'h100, 32'h40, 1'b0, 4'd1);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        chk("lat_one_edge_out_valid", 32'(out_valid), 32'd0);
        tick();
        @(negedge clk);
        chk("lat_two_edge_out_valid", 32'(out_valid), 32'd1);
        chk("lt_s_taken", 32'(out_taken), 32'd1);
        chk("lt_s_mispr", 32'(out_mispredict), 32'd1);
        wait_drain("drain_first");

        // Back-to-back stream, out_ready high
        tick();
        for (int i = 0; i < 5; i++) begin
            case (i)
                0: drive(32'hFFFF_FFFF, 32'd1, 3'b110, 32'hFFFF_FFFC, 32'h40, 1'b0, 4'd2);
                1: drive(32'd5, 32'd5, 3'b000, 32'h1000, 32'hFFFF_FFF0, 1'b1, 4'd3);
                2: drive(32'd5, 32'd5, 3'b001, 32'h1000, 32'h10, 1'b1, 4'd4);
                3: drive(32'h8000_0000, 32'h7FFF_FFFF, 3'b011, 32'h2000, 32'h8, 1'b0, 4'd5);
                default: drive(32'h8000_0000, 32'h7FFF_FFFF, 3'b111, 32'hFFFF_FFF0, 32'h20, 1'b0, 4'd6);
            endcase
            @(negedge clk);
            chk("stream_in_ready", 32'(in_ready), 32'd1);
            if (i == 2) chk("lt_u_target_wrap", out_target, 32'h0000_0000);
            tick();
        end
        in_valid = 1'b0;
        wait_drain("drain_stream");

        // Stall: three back-to-back ops, consumer blocked for 4 cycles
        out_ready = 1'b0;
        drive(32'd1, 32'd2, 3'b010, 32'h300, 32'h4, 1'b1, 4'd1);
        tick();
        drive(32'd3, 32'd3, 3'b000, 32'h400, 32'h8, 1'b0, 4'd2);
        tick();
        drive(32'd7, 32'd3, 3'b110, 32'h500, 32'hC, 1'b1, 4'd3);
        @(negedge clk);
        chk("stall_in_ready", 32'(in_ready), 32'd0);
        repeat (3) tick();
        @(negedge clk);
        chk("stall_held_tag", 32'(out_tag), 32'd1);
        tick();
        out_ready = 1'b1;
        @(negedge clk);
        chk("unstall_in_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        wait_drain("drain_stall");

        // Flush with FULL occupancy; a new op offered during flush must be dropped
        out_ready = 1'b0;
        drive(32'd9, 32'd9, 3'b000, 32'h600, 32'h10, 1'b0, 4'd7);
        tick();
        drive(32'd9, 32'd8, 3'b001, 32'h700, 32'h10, 1'b0, 4'd8);
        tick();
        drive(32'd1, 32'd1, 3'b000, 32'h800, 32'h10, 1'b0, 4'd9);
        flush = 1'b1;
        @(negedge clk);
        chk("flush_in_ready", 32'(in_ready), 32'd0);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        q.delete();
        @(negedge clk);
        chk("post_flush_out_valid", 32'(out_valid), 32'd0);
        chk("post_flush_in_ready",  32'(in_ready),  32'd1);
        out_ready = 1'b1;
        repeat (4) tick();

        // Reset pulse while stalled with results pending
        out_ready = 1'b0;
        drive(32'd2, 32'd1, 3'b011, 32'h900, 32'h20, 1'b0, 4'd10);
        tick();
        drive(32'd2, 32'd1, 3'b010, 32'hA00, 32'h20, 1'b1, 4'd11);
        tick();
        in_valid = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_out_valid", 32'(out_valid), 32'd0);
        chk("rst_mid_out_tag",   32'(out_tag),   32'd0);
`ifdef BRANCH_UNIT_STATS_EN
        chk("rst_mid_stat", stat_mispredicts, 32'd0);
`endif
        q.delete();
        @(posedge clk);
        #2 rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("resume_in_ready", 32'(in_ready), 32'd1);
        tick();
        drive(32'd4, 32'd4, 3'b001, 32'hB00, 32'h30, 1'b1, 4'd12);
        tick();
        in_valid = 1'b0;
        wait_drain("drain_resume");

`ifdef BRANCH_UNIT_STATS_EN
        // Saturation: preload near max, then two mispredicts
        force dut.stat_q = 32'hFFFF_FFFE;
        #1 release dut.stat_q;
        tick();
        drive(32'd1, 32'd1, 3'b000, 32'hC00, 32'h4, 1'b0, 4'd13);
        tick();
        drive(32'd1, 32'd2, 3'b000, 32'hD00, 32'h4, 1'b1, 4'd14);
        tick();
        in_valid = 1'b0;
        wait_drain("drain_stats");
        tick();
        @(negedge clk);
        chk("stat_saturated", stat_mispredicts, 32'hFFFF_FFFF);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
